// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmitter:
//                FSM state encoding, data width and idle line level.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baudgen_tx.sv
`default_nettype none
// ============================================================================
//  Module      : baudgen_tx
//  Description : Bit-period tick generator for the UART transmitter.
//                Counts 0..BAUDRATE-1 while enabled and emits a one-cycle
//                tick on the last count. Held at 0 while disabled, so the
//                first period after enabling is always full length.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-high reset
//                clk_ena - count enable (transmitter busy)
//                clk_out - one-cycle tick at end of each bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module baudgen_tx #(
    parameter int BAUDRATE = 125000000 / 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int            c_CNT_W = (BAUDRATE > 2) ? $clog2(BAUDRATE) : 1;
    localparam [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(BAUDRATE - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (clk_ena && (cnt_q != c_LAST)) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_out = clk_ena && (cnt_q == c_LAST);

endmodule : baudgen_tx
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, 8 data bits LSB first, 1 stop bit.
//                One byte accepted per start/ready handshake.
//                Optional parity bit enabled by macro UART_TX_PARITY_EN
//                (PARITY_ODD selects odd parity, otherwise even).
//  Ports       : clk   - system clock
//                rst   - asynchronous active-high reset
//                start - send request, sampled while ready=1
//                data  - byte captured on the accepting cycle
//                tx    - registered serial output, idles high
//                ready - high when idle and able to accept a byte
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUDRATE   = 125000000 / 115200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      tx,
    output logic                      ready
);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bitcnt_q, bitcnt_d;
    logic                      tx_q, tx_d;
    logic                      baud_tick;

`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`else
    logic                      w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    baudgen_tx #(
        .BAUDRATE (BAUDRATE)
    ) u_baudgen (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (state_q != IDLE),
        .clk_out (baud_tick)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d  = data;
                    bitcnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^data) ^ PARITY_ODD;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d  = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: tx level is computed for the upcoming state so that the
    // line changes on the same edge as the state, straight from a flop.
    always_comb begin
        tx_d  = UART_IDLE_LEVEL;
        ready = (state_q == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    assign tx = tx_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx with BAUDRATE=4.
//                Frames are checked cycle by cycle against levels built
//                from the byte being sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_BAUD = 4;
    localparam bit c_PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int c_NBITS = 11;
`else
    localparam int c_NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx #(
        .BAUDRATE   (c_BAUD),
        .PARITY_ODD (c_PODD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sends byte b starting at the current negedge and checks every cycle of
    // the frame plus the idle cycle after it. hold keeps start asserted for
    // back-to-back operation; dist_at (>=0) pulses start with data=0xFF in
    // that frame cycle; data is switched to next_data once the byte is taken.
    task automatic run_frame(input logic [7:0] b, input logic hold,
                             input int dist_at, input logic [7:0] next_data);
        logic [10:0] lv;
        lv = '1;
        lv[0] = 1'b0;
        for (int k = 0; k < 8; k++) lv[1+k] = b[k];
`ifdef UART_TX_PARITY_EN
        lv[9] = (^b) ^ c_PODD;
`endif
        start = 1'b1;
        data  = b;
        @(negedge clk);
        if (!hold) start = 1'b0;
        data = next_data;
        for (int i = 0; i < c_NBITS * c_BAUD; i++) begin
            chk($sformatf("tx[%02h] c%0d", b, i), tx, lv[i / c_BAUD]);
            chk($sformatf("ready[%02h] c%0d", b, i), ready, 1'b0);
            if (i == dist_at) begin
                start = 1'b1;
                data  = 8'hFF;
            end else if (i == dist_at + 1 && !hold) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk($sformatf("idle tx[%02h]", b), tx, 1'b1);
        chk($sformatf("idle ready[%02h]", b), ready, 1'b1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset tx", tx, 1'b1);
        chk("reset ready", ready, 1'b1);
        rst = 1'b0;

        // Idle line with no request
        repeat (3) @(negedge clk);
        chk("idle tx", tx, 1'b1);
        chk("idle ready", ready, 1'b1);

        // Alternating pattern
        run_frame(8'h55, 1'b0, -1, 8'h55);

        // Start request and data change while busy are ignored
        @(negedge clk);
        run_frame(8'hA3, 1'b0, 10, 8'hA3);

        // Back-to-back frames with start held high
        @(negedge clk);
        run_frame(8'h00, 1'b1, -1, 8'hFF);
        run_frame(8'hFF, 1'b0, -1, 8'hFF);

        // Abort mid-frame with reset
        @(negedge clk);
        start = 1'b1;
        data  = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("abort pre tx c%0d", i), tx, (i < c_BAUD) ? 1'b0 : (i / c_BAUD <= 4));
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("abort tx", tx, 1'b1);
        chk("abort ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post abort tx", tx, 1'b1);
            chk("post abort ready", ready, 1'b1);
        end
        run_frame(8'h3C, 1'b0, -1, 8'h3C);

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        run_frame(8'h07, 1'b0, -1, 8'h07);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
